// File: rtl/sdm_conv_ctrl.sv
// sdm_conv_ctrl: sequencer for a first-order sigma-delta modulator front end.
// It holds the modulator integrators in reset, lets the loop settle for a few
// discarded frames, then forms signed sinc1 frame sums over OSR samples and
// hands them to a consumer through a valid/ready handshake.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   start           begin a conversion (honoured only in IDLE)
//   continuous      1 = keep converting frame after frame, 0 = one frame
//   abort           drop the current sequence and return to IDLE
//   osr_sel         oversampling ratio: 00=64 01=128 10=256 11=512
//   sdm_dout        modulator bitstream, sampled while sdm_en=1
//   sdm_en, sdm_rst modulator clock enable / integrator hold
//   cic_clr         one-cycle clear to the decimator on entry to SETTLE
//   frame_strobe    high on the last cycle of every OSR frame
//   result          signed 11-bit frame sum, result_valid/result_ready handshake
//   overrun         sticky: an unread result was overwritten
//   busy            high whenever the sequencer is not IDLE
module sdm_conv_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  input  logic [1:0]  osr_sel,
  input  logic        sdm_dout,
  output logic        sdm_en,
  output logic        sdm_rst,
  output logic        cic_clr,
  output logic        frame_strobe,
  output logic [10:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        overrun,
  output logic        busy
);

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, MRST, SETTLE, CONV} state_t;

  state_t             state, state_next;
  logic [1:0]         osr_lat;
  logic [8:0]         frame_cnt;
  logic [8:0]         frame_last;
  logic [15:0]        rst_cnt;
  logic [15:0]        settle_cnt;
  logic signed [10:0] acc;
  logic signed [10:0] acc_sum;
  logic signed [10:0] pend_sum;
  logic               pend;
  logic               start_ok;

  assign start_ok = (state == IDLE) && start;

  // Sum including the sample on the current edge, so the frame-end value
  // captures all OSR samples.
  assign acc_sum = sdm_dout ? (acc + 11'sd1) : (acc - 11'sd1);

  always_comb begin
    case (osr_lat)
      2'b00:   frame_last = 9'd63;
      2'b01:   frame_last = 9'd127;
      2'b10:   frame_last = 9'd255;
      default: frame_last = 9'd511;
    endcase
  end

  always_comb begin
    state_next   = state;
    sdm_en       = 1'b0;
    sdm_rst      = 1'b1;
    busy         = 1'b1;
    frame_strobe = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = MRST;
      end
      MRST: begin
        if (rst_cnt == RST_LAST) state_next = SETTLE;
      end
      SETTLE: begin
        sdm_en       = 1'b1;
        sdm_rst      = 1'b0;
        frame_strobe = (frame_cnt == frame_last);
        if (frame_strobe && (settle_cnt == SETTLE_LAST)) state_next = CONV;
      end
      CONV: begin
        sdm_en       = 1'b1;
        sdm_rst      = 1'b0;
        frame_strobe = (frame_cnt == frame_last);
        if (frame_strobe && !continuous) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides every other transition, including a frame end.
    if ((state != IDLE) && abort) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      osr_lat <= 2'b00;
      cic_clr <= 1'b0;
    end else begin
      state   <= state_next;
      cic_clr <= (state == MRST) && (state_next == SETTLE);
      if (start_ok) osr_lat <= osr_sel;
    end
  end

  // Counters and accumulator are idle-cleared, so an abort or a finished
  // conversion always leaves them ready for the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt  <= 9'd0;
      rst_cnt    <= 16'd0;
      settle_cnt <= 16'd0;
      acc        <= 11'sd0;
    end else if (abort || (state == IDLE)) begin
      frame_cnt  <= 9'd0;
      rst_cnt    <= 16'd0;
      settle_cnt <= 16'd0;
      acc        <= 11'sd0;
    end else begin
      if (state == MRST) rst_cnt <= rst_cnt + 16'd1;
      if (sdm_en) begin
        if (frame_strobe) begin
          frame_cnt <= 9'd0;
          acc       <= 11'sd0;
          if (state == SETTLE) settle_cnt <= settle_cnt + 16'd1;
        end else begin
          frame_cnt <= frame_cnt + 9'd1;
          acc       <= acc_sum;
        end
      end
    end
  end

  // A CONV frame sum is captured at the frame-end edge and published one
  // edge later; the publish edge is where the handshake and overrun are
  // resolved. A captured sum is always published, even if the sequencer
  // has meanwhile gone back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend         <= 1'b0;
      pend_sum     <= 11'sd0;
      result       <= 11'd0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      pend <= (state == CONV) && frame_strobe && !abort;
      if ((state == CONV) && frame_strobe && !abort) pend_sum <= acc_sum;
      if (pend) begin
        result       <= pend_sum;
        result_valid <= 1'b1;
        if (result_valid && !result_ready) overrun <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
      if (start_ok) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdm_conv_ctrl.sv
// tb_sdm_conv_ctrl: directed bench for sdm_conv_ctrl with default parameters
// (RST_CYCLES=4, SETTLE_FRAMES=2). Conversion vectors are table driven; the
// overrun, abort, reset and handshake corner cases are hand-written sequences.
// Edge numbering: the edge that accepts start is edge 0.
module tb_sdm_conv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        continuous;
  logic        abort;
  logic [1:0]  osr_sel;
  logic        sdm_dout;
  logic        sdm_en;
  logic        sdm_rst;
  logic        cic_clr;
  logic        frame_strobe;
  logic [10:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        overrun;
  logic        busy;

  sdm_conv_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .continuous   (continuous),
    .abort        (abort),
    .osr_sel      (osr_sel),
    .sdm_dout     (sdm_dout),
    .sdm_en       (sdm_en),
    .sdm_rst      (sdm_rst),
    .cic_clr      (cic_clr),
    .frame_strobe (frame_strobe),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Pattern modes: 0 = all zeros, 1 = all ones, 2 = alternating (1 on odd
  // edges), 3 = one except every 4th edge. Any OSR-long window of modes 2/3
  // has a fixed ones count, so expected sums do not depend on alignment.
  typedef struct {
    logic [1:0] osr;
    int         mode;
    int         exp_result;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  int n_vec  = 0;
  int n_miss = 0;
  int edge_k;
  int pat_mode;
  int strobe_cnt;
  int cic_cnt;
  int first_en;
  int en_low_cnt;
  int valid_cnt;
  int lat;

  function automatic logic pat(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2) == 1;
      default: return (k % 4) != 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock: drive the bitstream for the coming edge, sample #1 after it.
  task automatic step();
    @(negedge clk);
    sdm_dout = pat(pat_mode, edge_k + 1);
    @(posedge clk);
    edge_k++;
    #1;
    if (frame_strobe) strobe_cnt++;
    if (cic_clr) cic_cnt++;
    if (sdm_en && (first_en < 0)) first_en = edge_k;
    if (!sdm_en) en_low_cnt++;
    if (result_valid) valid_cnt++;
  endtask

  task automatic step_until(input int k);
    while (edge_k < k) step();
  endtask

  task automatic applyStimulus(input logic [1:0] osr, input logic cont);
    @(negedge clk);
    osr_sel    = osr;
    continuous = cont;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    edge_k     = 0;
    strobe_cnt = 0;
    cic_cnt    = 0;
    first_en   = -1;
    en_low_cnt = 0;
    valid_cnt  = 0;
  endtask

  task automatic run_to_valid(input int budget, output int l);
    l = -1;
    while (edge_k < budget) begin
      step();
      if (result_valid) begin
        l = edge_k;
        break;
      end
    end
  endtask

  task automatic pulse_ready();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_sdm_rst"}, int'(sdm_rst), 1);
    checkOutput({tag, "_sdm_en"}, int'(sdm_en), 0);
    checkOutput({tag, "_cic_clr"}, int'(cic_clr), 0);
    checkOutput({tag, "_strobe"}, int'(frame_strobe), 0);
    checkOutput({tag, "_result"}, int'(result), 0);
    checkOutput({tag, "_valid"}, int'(result_valid), 0);
    checkOutput({tag, "_overrun"}, int'(overrun), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Latency = 1 + 4 + 3*OSR; mode 3 sum = OSR/2 (3/4 ones minus 1/4 zeros).
    vecs[0] = '{2'd0, 1,   64,  197};
    vecs[1] = '{2'd0, 2,    0,  197};
    vecs[2] = '{2'd0, 3,   32,  197};
    vecs[3] = '{2'd1, 1,  128,  389};
    vecs[4] = '{2'd1, 3,   64,  389};
    vecs[5] = '{2'd2, 0, -256,  773};
    vecs[6] = '{2'd3, 2,    0, 1541};
    vecs[7] = '{2'd3, 0, -512, 1541};

    reset        = 1'b1;
    start        = 1'b0;
    continuous   = 1'b0;
    abort        = 1'b0;
    osr_sel      = 2'b00;
    sdm_dout     = 1'b0;
    result_ready = 1'b0;
    pat_mode     = 0;
    edge_k       = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      pat_mode = vecs[i].mode;
      applyStimulus(vecs[i].osr, 1'b0);
      run_to_valid(vecs[i].exp_lat + 20, lat);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_result", i), int'($signed(result)), vecs[i].exp_result);
      checkOutput($sformatf("v%0d_strobes", i), strobe_cnt, 3);
      checkOutput($sformatf("v%0d_cic_clr", i), cic_cnt, 1);
      checkOutput($sformatf("v%0d_first_en", i), first_en, 4);
      checkOutput($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      checkOutput($sformatf("v%0d_overrun", i), int'(overrun), 0);
      pulse_ready();
      checkOutput($sformatf("v%0d_valid_clear", i), int'(result_valid), 0);
    end

    // Continuous with no consumer: second CONV frame overwrites -> overrun.
    // Frame 2 samples edges 197..260: one 1 (edge 197) then 63 zeros = -62.
    pat_mode = 1;
    applyStimulus(2'd0, 1'b1);
    run_to_valid(250, lat);
    checkOutput("ovr_first_lat", lat, 197);
    checkOutput("ovr_first_flag", int'(overrun), 0);
    pat_mode = 0;
    step_until(261);
    checkOutput("ovr_second_valid", int'(result_valid), 1);
    checkOutput("ovr_second_result", int'($signed(result)), -62);
    checkOutput("ovr_flag", int'(overrun), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("ovr_abort_busy", int'(busy), 0);
    checkOutput("ovr_abort_valid", int'(result_valid), 1);
    checkOutput("ovr_abort_result", int'($signed(result)), -62);
    checkOutput("ovr_abort_flag", int'(overrun), 1);
    pulse_ready();
    checkOutput("ovr_valid_clear", int'(result_valid), 0);

    // Start held during CONV is ignored; ready on the publish edge keeps
    // result_valid high without flagging overrun.
    pat_mode = 1;
    applyStimulus(2'd0, 1'b1);
    checkOutput("hs_overrun_cleared", int'(overrun), 0);
    run_to_valid(250, lat);
    checkOutput("hs_first_lat", lat, 197);
    start      = 1'b1;
    en_low_cnt = 0;
    step_until(260);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    start        = 1'b0;
    checkOutput("hs_start_ignored", en_low_cnt, 0);
    checkOutput("hs_valid_held", int'(result_valid), 1);
    checkOutput("hs_overrun", int'(overrun), 0);
    checkOutput("hs_result", int'($signed(result)), 64);
    pulse_ready();
    checkOutput("hs_valid_clear", int'(result_valid), 0);

    // Abort on a CONV frame-end edge (324) wins: nothing is published.
    step_until(323);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    checkOutput("abort_fe_valid", int'(result_valid), 0);
    checkOutput("abort_fe_busy", int'(busy), 0);

    // Abort sampled at edge 101, then a clean conversion.
    pat_mode = 1;
    applyStimulus(2'd0, 1'b0);
    step_until(100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_sdm_rst", int'(sdm_rst), 1);
    checkOutput("abort_sdm_en", int'(sdm_en), 0);
    valid_cnt = 0;
    step_until(400);
    checkOutput("abort_no_valid", valid_cnt, 0);
    applyStimulus(2'd0, 1'b0);
    run_to_valid(250, lat);
    checkOutput("after_abort_lat", lat, 197);
    checkOutput("after_abort_result", int'($signed(result)), 64);

    // Reset in CONV with a pending valid result clears everything at once.
    applyStimulus(2'd0, 1'b1);
    checkOutput("rst_pre_valid", int'(result_valid), 1);
    run_to_valid(250, lat);
    step_until(207);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset     = 1'b0;
    valid_cnt = 0;
    edge_k    = 0;
    step_until(300);
    checkOutput("post_reset_no_valid", valid_cnt, 0);
    checkOutput("post_reset_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sdm_conv_ctrl.md
SDM_CONV_CTRL -- requirements
Module: sdm_conv_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 4: number of cycles the modulator is held in reset before a conversion.
REQ-002 Parameter SETTLE_FRAMES, default 2: number of OSR frames discarded after modulator reset.
REQ-003 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request a conversion; accepted only in IDLE.
REQ-006 continuous  input  1  1 = free-running frames; 0 = single frame.
REQ-007 abort  input  1  terminate the current sequence.
REQ-008 osr_sel  input  2  OSR select: 00=64, 01=128, 10=256, 11=512; latched when start is accepted.
REQ-009 sdm_dout  input  1  modulator bitstream, valid at each rising clk edge while sdm_en=1.
REQ-010 sdm_en  output  1  modulator clock enable.
REQ-011 sdm_rst  output  1  active-high hold of the modulator integrators.
REQ-012 cic_clr  output  1  one-cycle clear pulse to the downstream decimator.
REQ-013 frame_strobe  output  1  one-cycle pulse on the last cycle of every OSR frame.
REQ-014 result  output  11  signed sinc1 frame sum.
REQ-015 result_valid  output  1  result available.
REQ-016 result_ready  input  1  consumer accepts result.
REQ-017 overrun  output  1  sticky flag: an unread result was overwritten.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The block SHALL implement the FSM states IDLE, MRST, SETTLE and CONV.
REQ-020 In IDLE, outputs SHALL be: sdm_rst=1, sdm_en=0, busy=0.
REQ-021 In IDLE, start=1 SHALL latch osr_sel, clear overrun, and enter MRST on the next edge.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 MRST SHALL last exactly RST_CYCLES cycles with sdm_rst=1 and sdm_en=0, then enter SETTLE.
REQ-024 On entry to SETTLE, cic_clr SHALL pulse for 1 cycle; in SETTLE and CONV, sdm_rst=0 and sdm_en=1.
REQ-025 A frame counter SHALL count 0..OSR-1 on cycles with sdm_en=1; frame_strobe SHALL assert when the count equals OSR-1, and the count SHALL then wrap to 0.
REQ-026 The accumulator SHALL add +1 for sdm_dout=1 and -1 for sdm_dout=0 each enabled cycle, and SHALL clear at every frame wrap.
REQ-027 The accumulator range SHALL be -512..+512 with no saturation needed; 11-bit two's complement.
REQ-028 After SETTLE_FRAMES frame_strobes in SETTLE, the FSM SHALL enter CONV; SETTLE frame sums SHALL be discarded.
REQ-029 In CONV at frame end, result SHALL load the full frame sum (including the final sample) and result_valid SHALL assert on the next edge.
REQ-030 The result_valid/result_ready handshake SHALL complete when result_valid=1 and result_ready=1 at an edge; result_valid SHALL then clear unless a new result loads on the same edge, in which case result_valid stays 1 and overrun is not set.
REQ-031 If a new result loads while result_valid=1 and result_ready=0, result SHALL be overwritten and overrun set to 1.
REQ-032 continuous SHALL be sampled at each CONV frame end: 1 keeps CONV; 0 returns to IDLE.
REQ-033 A pending result SHALL remain held across the return to IDLE until accepted.
REQ-034 abort=1 in any non-IDLE state SHALL enter IDLE on the next edge and clear the accumulator and counters.
REQ-035 abort SHALL NOT alter result, result_valid or overrun.
REQ-036 abort SHALL take priority over a simultaneous frame end; no result loads on that edge.
REQ-037 Latency: with start accepted at edge 0, the first result_valid SHALL rise at edge 1+RST_CYCLES+(SETTLE_FRAMES+1)*OSR.

Reset
REQ-038 reset=1 SHALL immediately force: IDLE, sdm_rst=1, sdm_en=0, cic_clr=0, frame_strobe=0, result=0, result_valid=0, overrun=0, busy=0, counters and accumulator cleared.
REQ-039 Reset asserted mid-conversion SHALL discard all progress; no result SHALL be produced until a new start.

Verification
REQ-040 Defaults, osr_sel=00, continuous=0, sdm_dout=1 constant, start pulse -> result=+64, result_valid rises at edge 197, then IDLE.
REQ-041 osr_sel=11, sdm_dout alternating 1/0 -> result=0; with sdm_dout=0 constant -> result=-512 (11'h600).
REQ-042 continuous=1, OSR 64, result_ready=0 -> overrun=1 after the second CONV frame; result holds the latest frame sum.
REQ-043 abort at edge 100 after start -> IDLE at edge 101, sdm_rst=1, no result_valid; a new start then completes normally.
REQ-044 reset asserted mid-CONV with result_valid=1 -> all outputs at reset values asynchronously, before the next clk edge.
REQ-045 start during CONV and result_ready pulsed on the frame-end edge -> start ignored, result_valid stays 1, overrun=0.
